// File: rtl/iram_arbiter_pkg.sv
// iram_arbiter_pkg
//   Shared definitions for the internal-RAM arbiter: FSM state encoding and
//   the fixed requester indices of the 8051 integration.
package iram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;

endpackage

// File: rtl/iram_arbiter_if.sv
// iram_arbiter_if
//   Bundles the requester side (req/we/addr/wdata in, gnt/ack/rdata/busy out)
//   and the RAM side (mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in).
//   slave  : view of the arbiter itself
//   master : view of the surrounding logic (requesters plus RAM)
//   addr/wdata are flat buses, requester i at [i*W +: W].
interface iram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N_REQ  = 3
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic                    busy;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/iram_arbiter_arb_prio_pick.sv
// arb_prio_pick
//   Combinational lowest-index one-hot picker.
//   req  : candidate mask, N bits
//   pick : one-hot of the lowest set bit of req, zero when req is zero
module arb_prio_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] pick
);
  // Two's complement isolates the lowest set bit.
  assign pick = req & (~req + N'(1));
endmodule

// File: rtl/iram_arbiter.sv
// iram_arbiter
//   Shares the single-port internal RAM among N_REQ requesters
//   (0 = core fetch, 1 = core data, 2 = debug/loader). Fixed priority,
//   lowest index wins, one transaction in flight.
//   Optional starvation guard: define IRAM_ARB_STARVE_GUARD_EN.
// Ports
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : iram_arbiter_if.slave, requester handshake and RAM port
//
// state | meaning
// IDLE  | nothing in flight, arbitrate on any req
// ISSUE | mem_en pulse for the latched winner
// WAIT  | count RAM latency, capture read data at MEM_LAT
// DONE  | ack pulse, re-arbitrate for back-to-back issue
module iram_arbiter
  import iram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int N_REQ      = 3,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clock,
  input logic          reset,
  iram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  generate
    if (N_REQ < 2 || MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_cfg
      $error("iram_arbiter: unsupported parameter set");
    end
  endgenerate

  arb_state_e        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              lat_we;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [N_REQ-1:0]  raw_pick;
  logic [N_REQ-1:0]  win_oh;
  logic              arb_fire;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  arb_prio_pick #(.N(N_REQ)) u_pick_raw (
    .req  (bus.req),
    .pick (raw_pick)
  );

  assign arb_fire = ((state == IDLE) || (state == DONE)) && (|bus.req);

`ifdef IRAM_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0]  starve_cnt [N_REQ];
  logic [N_REQ-1:0] starved;
  logic [N_REQ-1:0] starved_pick;

  always_comb begin
    starved = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starved[i] = bus.req[i] && (starve_cnt[i] == SC_W'(STARVE_MAX));
    end
  end

  arb_prio_pick #(.N(N_REQ)) u_pick_starved (
    .req  (starved),
    .pick (starved_pick)
  );

  assign win_oh = (|starved_pick) ? starved_pick : raw_pick;

  // Losers of an arbitration count up (saturating); the winner clears.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) starve_cnt[i] <= '0;
    end else if (arb_fire) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (win_oh[i]) begin
          starve_cnt[i] <= '0;
        end else if (bus.req[i] && (starve_cnt[i] != SC_W'(STARVE_MAX))) begin
          starve_cnt[i] <= starve_cnt[i] + SC_W'(1);
        end
      end
    end
  end
`else
  assign win_oh = raw_pick;
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE, DONE: begin
          if (arb_fire) begin
            // Outputs for ISSUE are set up here so mem_en is registered.
            state       <= ISSUE;
            gnt_q       <= win_oh;
            busy_q      <= 1'b1;
            lat_we      <= sel_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end else begin
            state  <= IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= CNT_W'(1);
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(MEM_LAT)) begin
            if (!lat_we) rdata_q <= bus.mem_rdata;
            ack_q <= gnt_q;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_iram_arbiter.sv
// tb_iram_arbiter
//   Self-checking bench for iram_arbiter (MEM_LAT=2, STARVE_MAX=4).
//   A transaction-level model predicts grant order, ack cycles and data.
module tb_iram_arbiter;
  import iram_arbiter_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int N_REQ      = 3;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int PERIOD     = 2 + MEM_LAT;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  iram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ)) bus_if ();

  iram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ),
    .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // RAM device with MEM_LAT read pipeline and a preload port.
  logic [7:0] ram [256];
  logic [7:0] pipe [MEM_LAT];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;

  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (bus_if.mem_en && bus_if.mem_we) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
    pipe[0] <= bus_if.mem_en ? ram[bus_if.mem_addr] : 8'($urandom);
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus_if.mem_rdata = pipe[MEM_LAT-1];

  // Reference model state
  logic [7:0] ref_mem [256];
  int         ref_cnt [N_REQ];
  logic [7:0] ref_rdata;
  int         exp_order [8];
  logic [7:0] exp_rd [8];
  int         exp_n;

  // Driver inputs and observations
  logic       drv_we [N_REQ];
  logic [7:0] drv_addr [N_REQ];
  logic [7:0] drv_wdata [N_REQ];
  int         obs_n_ack, obs_n_en, obs_bad, obs_gap;
  bit         obs_timeout;
  int         obs_idx [8], obs_at [8];
  logic [7:0] obs_rd [8];
  int         en_at [8];
  logic [7:0] en_addr [8], en_wd [8];
  logic       en_we [8];
  logic [2:0] en_gnt [8];

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Arbitration rules applied to a set of simultaneous requests, each
  // requester withdrawing once served.
  task automatic model_round(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] pend;
    int w;
    pend  = mask;
    exp_n = 0;
    while (pend != '0) begin
      w = -1;
`ifdef IRAM_ARB_STARVE_GUARD_EN
      for (int i = 0; i < N_REQ; i++)
        if (w < 0 && pend[i] && ref_cnt[i] == STARVE_MAX) w = i;
`endif
      for (int i = 0; i < N_REQ; i++)
        if (w < 0 && pend[i]) w = i;
      for (int i = 0; i < N_REQ; i++)
        if (pend[i] && i != w && ref_cnt[i] < STARVE_MAX) ref_cnt[i]++;
      ref_cnt[w] = 0;
      pend[w] = 1'b0;
      exp_order[exp_n] = w;
      if (drv_we[w]) ref_mem[drv_addr[w]] = drv_wdata[w];
      else ref_rdata = ref_mem[drv_addr[w]];
      exp_rd[exp_n] = ref_rdata;
      exp_n++;
    end
  endtask

  task automatic run_round(input logic [N_REQ-1:0] mask);
    int n, need;
    n = 0;
    need = $countones(mask);
    obs_n_ack = 0; obs_n_en = 0; obs_bad = 0; obs_gap = 0; obs_timeout = 0;
    @(negedge clock);
    for (int i = 0; i < N_REQ; i++) begin
      bus_if.we[i] = drv_we[i];
      bus_if.addr[i*ADDR_W +: ADDR_W] = drv_addr[i];
      bus_if.wdata[i*DATA_W +: DATA_W] = drv_wdata[i];
    end
    bus_if.req = mask;
    while (obs_n_ack < need) begin
      @(negedge clock);
      n++;
      if (!bus_if.busy) obs_gap++;
      if (bus_if.mem_en) begin
        if (obs_n_en < 8) begin
          en_at[obs_n_en] = n; en_addr[obs_n_en] = bus_if.mem_addr;
          en_we[obs_n_en] = bus_if.mem_we; en_wd[obs_n_en] = bus_if.mem_wdata;
          en_gnt[obs_n_en] = bus_if.gnt;
        end
        obs_n_en++;
      end
      if (bus_if.ack != '0) begin
        if (!$onehot(bus_if.ack)) obs_bad++;
        if (obs_n_ack < 8) begin
          obs_at[obs_n_ack] = n;
          obs_rd[obs_n_ack] = bus_if.rdata;
          for (int i = 0; i < N_REQ; i++) if (bus_if.ack[i]) obs_idx[obs_n_ack] = i;
        end
        obs_n_ack++;
        bus_if.req = bus_if.req & ~bus_if.ack;
      end
      if (n > 8 * PERIOD + 4) begin
        obs_timeout = 1'b1;
        break;
      end
    end
    bus_if.req = '0;
  endtask

  task automatic test_reset;
    bus_if.req = 3'b111; bus_if.we = 3'b000; bus_if.addr = '0; bus_if.wdata = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus_if.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", bus_if.gnt); end
    checks++;
    if (bus_if.ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", bus_if.ack); end
    checks++;
    if ({bus_if.mem_en, bus_if.mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b want 00", {bus_if.mem_en, bus_if.mem_we}); end
    checks++;
    if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    checks++;
    if (bus_if.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus_if.rdata); end
    bus_if.req = '0;
    reset = 1'b1;
    ref_rdata = 8'h00;
    for (int i = 0; i < N_REQ; i++) ref_cnt[i] = 0;
  endtask

  task automatic test_single_read;
    preload(8'h30, 8'hA5);
    drv_we[REQ_DATA] = 1'b0; drv_addr[REQ_DATA] = 8'h30; drv_wdata[REQ_DATA] = 8'h00;
    model_round(3'b010);
    run_round(3'b010);
    checks++;
    if (obs_timeout || obs_n_ack != 1 || obs_idx[0] != REQ_DATA) begin errors++; $display("FAIL read_ack: got n=%0d idx=%0d to=%0d want n=1 idx=1", obs_n_ack, obs_idx[0], obs_timeout); end
    checks++;
    if (obs_at[0] != PERIOD) begin errors++; $display("FAIL read_latency: got %0d want %0d", obs_at[0], PERIOD); end
    checks++;
    if (obs_rd[0] !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h want a5", obs_rd[0]); end
    checks++;
    if (obs_n_en != 1 || en_at[0] != 1 || en_addr[0] !== 8'h30 || en_we[0] !== 1'b0) begin
      errors++; $display("FAIL read_mem_en: got cnt=%0d at=%0d addr=%h we=%b want 1/1/30/0", obs_n_en, en_at[0], en_addr[0], en_we[0]);
    end
    checks++;
    if (en_gnt[0] !== 3'b010) begin errors++; $display("FAIL read_gnt: got %b want 010", en_gnt[0]); end
    @(negedge clock);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.gnt !== 3'b000 || bus_if.mem_en !== 1'b0) begin
      errors++; $display("FAIL read_idle: got busy=%b gnt=%b en=%b want 0/000/0", bus_if.busy, bus_if.gnt, bus_if.mem_en);
    end
  endtask

  task automatic test_write;
    drv_we[REQ_LOAD] = 1'b1; drv_addr[REQ_LOAD] = 8'h7F; drv_wdata[REQ_LOAD] = 8'h3C;
    model_round(3'b100);
    run_round(3'b100);
    checks++;
    if (obs_n_en != 1 || en_we[0] !== 1'b1 || en_addr[0] !== 8'h7F || en_wd[0] !== 8'h3C) begin
      errors++; $display("FAIL write_mem: got cnt=%0d we=%b addr=%h wd=%h want 1/1/7f/3c", obs_n_en, en_we[0], en_addr[0], en_wd[0]);
    end
    checks++;
    if (obs_n_ack != 1 || obs_idx[0] != REQ_LOAD || obs_at[0] != PERIOD) begin
      errors++; $display("FAIL write_ack: got n=%0d idx=%0d at=%0d want 1/2/%0d", obs_n_ack, obs_idx[0], obs_at[0], PERIOD);
    end
    checks++;
    if (obs_rd[0] !== exp_rd[0]) begin errors++; $display("FAIL write_rdata_hold: got %h want %h", obs_rd[0], exp_rd[0]); end
    drv_we[REQ_DATA] = 1'b0; drv_addr[REQ_DATA] = 8'h7F;
    model_round(3'b010);
    run_round(3'b010);
    checks++;
    if (obs_rd[0] !== 8'h3C) begin errors++; $display("FAIL write_readback: got %h want 3c", obs_rd[0]); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    preload(8'h21, 8'h11);
    preload(8'h22, 8'h22);
    drv_we[REQ_FETCH] = 1'b0; drv_addr[REQ_FETCH] = 8'h21;
    drv_we[REQ_LOAD]  = 1'b0; drv_addr[REQ_LOAD]  = 8'h22;
    model_round(3'b101);
    run_round(3'b101);
    checks++;
    if (obs_timeout || obs_n_ack != 2 || obs_idx[0] != REQ_FETCH || obs_idx[1] != REQ_LOAD) begin
      errors++; $display("FAIL b2b_order: got n=%0d %0d,%0d want 2 0,2", obs_n_ack, obs_idx[0], obs_idx[1]);
    end
    checks++;
    if (obs_at[0] != PERIOD || obs_at[1] != 2 * PERIOD) begin
      errors++; $display("FAIL b2b_ack_time: got %0d,%0d want %0d,%0d", obs_at[0], obs_at[1], PERIOD, 2 * PERIOD);
    end
    checks++;
    if (obs_n_en != 2 || en_at[1] != obs_at[0] + 1 || en_addr[1] !== 8'h22) begin
      errors++; $display("FAIL b2b_issue: got cnt=%0d at=%0d addr=%h want 2/%0d/22", obs_n_en, en_at[1], en_addr[1], obs_at[0] + 1);
    end
    checks++;
    if (obs_gap != 0) begin errors++; $display("FAIL b2b_busy_gap: got %0d idle cycles want 0", obs_gap); end
    checks++;
    if (obs_rd[0] !== 8'h11 || obs_rd[1] !== 8'h22) begin
      errors++; $display("FAIL b2b_rdata: got %h,%h want 11,22", obs_rd[0], obs_rd[1]);
    end
    @(negedge clock);
  endtask

  task automatic test_starvation;
    int n, acks0, before2, ack2_at, drop_at, exp_before;
    logic [7:0] ack2_rd;
    logic [7:0] d0, d2;
    n = 0; acks0 = 0; before2 = -1; ack2_at = -1; drop_at = -1; ack2_rd = '0;
    d0 = 8'($urandom); d2 = 8'($urandom);
    preload(8'h10, d0);
    preload(8'h12, d2);
`ifdef IRAM_ARB_STARVE_GUARD_EN
    exp_before = STARVE_MAX;
`else
    exp_before = 10;
`endif
    @(negedge clock);
    bus_if.we = 3'b000;
    bus_if.addr[0*ADDR_W +: ADDR_W] = 8'h10;
    bus_if.addr[2*ADDR_W +: ADDR_W] = 8'h12;
    bus_if.req = 3'b101;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (bus_if.ack[2]) begin
        before2 = acks0; ack2_at = n; ack2_rd = bus_if.rdata;
        bus_if.req[2] = 1'b0;
      end
      if (bus_if.ack[0]) begin
        acks0++;
        if (before2 >= 0) begin bus_if.req[0] = 1'b0; break; end
`ifndef IRAM_ARB_STARVE_GUARD_EN
        if (acks0 == 10) begin bus_if.req[0] = 1'b0; drop_at = n; end
`endif
      end
      if (before2 >= 0 && !bus_if.req[0]) break;
    end
    bus_if.req = '0;
    checks++;
    if (n >= 200) begin errors++; $display("FAIL starve_timeout: got %0d cycles want <200", n); end
    checks++;
    if (before2 != exp_before) begin errors++; $display("FAIL starve_losses: got %0d want %0d", before2, exp_before); end
    checks++;
    if (ack2_at != (exp_before + 1) * PERIOD) begin errors++; $display("FAIL starve_ack2_time: got %0d want %0d", ack2_at, (exp_before + 1) * PERIOD); end
    checks++;
    if (ack2_rd !== d2) begin errors++; $display("FAIL starve_rdata: got %h want %h", ack2_rd, d2); end
`ifdef IRAM_ARB_STARVE_GUARD_EN
    ref_rdata = d0;
`else
    ref_rdata = d2;
    checks++;
    if (drop_at != 10 * PERIOD) begin errors++; $display("FAIL starve_fixed_prio: got drop at %0d want %0d", drop_at, 10 * PERIOD); end
`endif
    for (int i = 0; i < N_REQ; i++) ref_cnt[i] = 0;
    @(negedge clock);
  endtask

  task automatic test_random_traffic;
    logic [N_REQ-1:0] mask;
    for (int a = 0; a < 4; a++) preload(8'h40 + 8'(a), 8'($urandom));
    for (int r = 0; r < 12; r++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < N_REQ; i++) begin
        drv_we[i]    = 1'($urandom);
        drv_addr[i]  = 8'h40 + 8'($urandom_range(0, 3));
        drv_wdata[i] = 8'($urandom);
      end
      model_round(mask);
      run_round(mask);
      checks++;
      if (obs_timeout || obs_n_ack != exp_n || obs_bad != 0 || obs_n_en != exp_n || obs_gap != 0) begin
        errors++;
        $display("FAIL rnd_count r%0d: got ack=%0d en=%0d bad=%0d gap=%0d to=%0d want ack=en=%0d", r, obs_n_ack, obs_n_en, obs_bad, obs_gap, obs_timeout, exp_n);
      end
      for (int j = 0; j < exp_n && j < obs_n_ack && j < obs_n_en; j++) begin
        checks++;
        if (obs_idx[j] != exp_order[j] || obs_at[j] != (j + 1) * PERIOD || en_at[j] != j * PERIOD + 1) begin
          errors++;
          $display("FAIL rnd_order r%0d t%0d: got idx=%0d ack@%0d en@%0d want %0d/%0d/%0d", r, j, obs_idx[j], obs_at[j], en_at[j], exp_order[j], (j + 1) * PERIOD, j * PERIOD + 1);
        end
        checks++;
        if (en_addr[j] !== drv_addr[exp_order[j]] || en_we[j] !== drv_we[exp_order[j]] || en_gnt[j] !== 3'(1 << exp_order[j])) begin
          errors++;
          $display("FAIL rnd_mem r%0d t%0d: got addr=%h we=%b gnt=%b want %h/%b/%b", r, j, en_addr[j], en_we[j], en_gnt[j], drv_addr[exp_order[j]], drv_we[exp_order[j]], 3'(1 << exp_order[j]));
        end
        checks++;
        if (obs_rd[j] !== exp_rd[j]) begin
          errors++; $display("FAIL rnd_rdata r%0d t%0d: got %h want %h", r, j, obs_rd[j], exp_rd[j]);
        end
      end
      @(negedge clock);
      checks++;
      if (bus_if.busy !== 1'b0 || bus_if.mem_en !== 1'b0) begin
        errors++; $display("FAIL rnd_idle r%0d: got busy=%b en=%b want 0/0", r, bus_if.busy, bus_if.mem_en);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    int n, en_cnt, ack_at;
    logic [7:0] d, rd;
    n = 0; en_cnt = 0; ack_at = -1; rd = '0;
    d = 8'($urandom);
    preload(8'h55, d);
    @(negedge clock);
    bus_if.we = 3'b000;
    bus_if.addr[1*ADDR_W +: ADDR_W] = 8'h55;
    bus_if.req = 3'b010;
    while (n < 30) begin
      @(negedge clock);
      n++;
      if (bus_if.mem_en) en_cnt++;
      if (bus_if.ack != '0) begin ack_at = n; rd = bus_if.rdata; bus_if.req = '0; break; end
      if (n == 2) begin
        checks++;
        if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_before: got %b want 1", bus_if.busy); end
        reset = 1'b0;
      end
      if (n == 3) begin
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.gnt !== 3'b000 || bus_if.mem_en !== 1'b0 || bus_if.rdata !== 8'h00) begin
          errors++; $display("FAIL rstwait_idle: got busy=%b gnt=%b en=%b rdata=%h want 0/000/0/00", bus_if.busy, bus_if.gnt, bus_if.mem_en, bus_if.rdata);
        end
        reset = 1'b1;
      end
    end
    bus_if.req = '0;
    checks++;
    if (ack_at != 3 + PERIOD) begin errors++; $display("FAIL rstwait_ack_time: got %0d want %0d", ack_at, 3 + PERIOD); end
    checks++;
    if (en_cnt != 2) begin errors++; $display("FAIL rstwait_mem_en: got %0d want 2", en_cnt); end
    checks++;
    if (rd !== d) begin errors++; $display("FAIL rstwait_rdata: got %h want %h", rd, d); end
    @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      drv_we[i] = 1'b0; drv_addr[i] = '0; drv_wdata[i] = '0; ref_cnt[i] = 0;
    end
    ref_rdata = 8'h00;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_starvation();
    test_random_traffic();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 8'h00;
  end

endmodule
